// File: rtl/winograd_seq.sv
// Sequencer for the winograd 8-pair inner-product unit: streams chunks into the unit,
// tracks them across its latency and accumulates the raw out[0]+out[1] sums of a job.
module winograd_seq #(
    parameter int  IN_SIZE_0  = 8,
    parameter int  IN_SIZE_1  = 8,
    parameter int  LEN_W      = 8,
    parameter int  WG_LATENCY = 3,
    localparam int OUT_SIZE   = ((IN_SIZE_1 + 1) * 2) + 6,
    localparam int ACC_W      = OUT_SIZE + 1 + LEN_W
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    input  logic [LEN_W-1:0]                len_i,
    output logic                            busy_o,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [0:7][IN_SIZE_0-1:0]       in_0_i,
    input  logic [0:7][IN_SIZE_1-1:0]       in_1_i,
    output logic [0:7][IN_SIZE_0-1:0]       wg_in_0_o,
    output logic [0:7][IN_SIZE_1-1:0]       wg_in_1_o,
    input  logic [0:1][OUT_SIZE-1:0]        wg_out_i,
    output logic                            res_valid_o,
    input  logic                            res_ready_i,
    output logic [ACC_W-1:0]                res_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]            state;
    logic [LEN_W-1:0]      len;
    logic [LEN_W-1:0]      issued;
    logic [WG_LATENCY-1:0] in_flight;
    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      out_sum;
    logic                  fire;
    logic                  last_fire;
    logic                  tail;

    assign in_ready_o  = (state == STREAM) && (issued < len);
    assign fire        = in_valid_i && in_ready_o;
    assign last_fire   = fire && (issued == len - LEN_W'(1));
    assign tail        = in_flight[WG_LATENCY-1];
    assign busy_o      = (state != IDLE);
    assign res_valid_o = (state == DONE);
    assign res_o       = acc;

    // Both unit outputs are sign-extended to the accumulator width before summing
    assign out_sum = {{(ACC_W-OUT_SIZE){wg_out_i[0][OUT_SIZE-1]}}, wg_out_i[0]}
                   + {{(ACC_W-OUT_SIZE){wg_out_i[1][OUT_SIZE-1]}}, wg_out_i[1]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            len       <= '0;
            issued    <= '0;
            in_flight <= '0;
            acc       <= '0;
            wg_in_0_o <= '0;
            wg_in_1_o <= '0;
        end else begin
            // The tail bit marks the cycle when wg_out_i belongs to a real chunk
            in_flight <= (in_flight << 1) | WG_LATENCY'(fire);

            if (fire) begin
                wg_in_0_o <= in_0_i;
                wg_in_1_o <= in_1_i;
                issued    <= issued + LEN_W'(1);
            end else begin
                wg_in_0_o <= '0;
                wg_in_1_o <= '0;
            end

            if (tail) begin
                acc <= acc + out_sum;
            end

            case (state)
                IDLE: begin
                    if (start_i) begin
                        len    <= len_i;
                        issued <= '0;
                        acc    <= '0;
                        state  <= (len_i == '0) ? DONE : STREAM;
                    end
                end
                STREAM: begin
                    if (last_fire) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (in_flight == '0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
